keypad_scan: RTL and testbench



---
 rtl/keypad_pkg.sv | 30 +++
 rtl/keypad_debounce.sv | 70 +++++++
 rtl/keypad_scan.sv | 80 ++++++++
 tb/tb_keypad_scan.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, row FSM states and the matrix-position to
// key-index mapping for the 4x3 keypad scanner.
//   NUM_ROWS / NUM_COLS : matrix geometry
//   SNAP_W              : width of a full-scan snapshot (one bit per key)
//   KEY_STAR / KEY_HASH : key indices of '*' and '#'
//   key_index()         : (row, col) -> key index, digits map to themselves
package keypad_pkg;
    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int SNAP_W   = NUM_ROWS * NUM_COLS;
    localparam int KEY_STAR = 10;
    localparam int KEY_HASH = 11;

    typedef enum logic [1:0] {ROW0, ROW1, ROW2, ROW3} row_state_t;

    // Rows 0..2 hold digits 1..9 left to right; row 3 is '*', '0', '#'.
    function automatic logic [3:0] key_index(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] idx;
        if (row == 2'd3) begin
            case (col)
                2'd0:    idx = 4'(KEY_STAR);
                2'd1:    idx = 4'd0;
                default: idx = 4'(KEY_HASH);
            endcase
        end else begin
            idx = 4'(row * 3 + col + 1);
        end
        return idx;
    endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: accepts a new debounced key state once DB_CNT consecutive
// full-scan snapshots agree, then emits registered one-cycle press pulses.
//   clk, rst   : clock, synchronous active-low reset
//   scan_end   : strobe, snap holds a complete scan this cycle
//   snap       : full-scan snapshot, 1 = pressed
//   key_pulse  : one-cycle pulse per newly pressed key
//   key_code   : index of the last single-key press
//   key_valid  : exactly one key newly pressed this cycle
//   key_held   : any debounced key down
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DB_CNT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              scan_end,
    input  logic [SNAP_W-1:0] snap,
    output logic [SNAP_W-1:0] key_pulse,
    output logic [3:0]        key_code,
    output logic              key_valid,
    output logic              key_held
);
    localparam int CNT_W = $clog2(DB_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CNT);

    logic [SNAP_W-1:0] prev, deb, deb_nxt, pulse_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic [3:0]        code_nxt;
    logic              one_hot;

    always_comb begin
        cnt_nxt  = cnt;
        deb_nxt  = deb;
        if (scan_end) begin
            if (snap == prev)
                cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
            else
                cnt_nxt = CNT_W'(1);
            if (cnt_nxt == CNT_MAX)
                deb_nxt = snap;
        end
        // Rising edges of the debounced state; releases never pulse.
        pulse_nxt = deb_nxt & ~deb;
        one_hot   = ($countones(pulse_nxt) == 1);
        code_nxt  = key_code;
        for (int i = 0; i < SNAP_W; i++)
            if (pulse_nxt[i]) code_nxt = 4'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            prev      <= '0;
            cnt       <= '0;
            deb       <= '0;
            key_pulse <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            if (scan_end) prev <= snap;
            cnt       <= cnt_nxt;
            deb       <= deb_nxt;
            key_pulse <= pulse_nxt;
            key_valid <= one_hot;
            if (one_hot) key_code <= code_nxt;
            key_held  <= |deb_nxt;
        end
    end
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: scans a 4x3 active-low matrix keypad, synchronises the
// columns, builds full-scan snapshots and hands them to keypad_debounce.
//   clk, rst   : clock, synchronous active-low reset
//   col_in     : keypad columns, pulled up, 0 = pressed on driven row (async)
//   row_out    : active-low row drive, one row low at a time
//   key_pulse  : one-cycle press pulses (0-9 digits, 10 '*', 11 '#')
//   key_code   : index of the last single-key press
//   key_valid  : exactly one key newly pressed this cycle
//   key_held   : any debounced key down
module keypad_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1000,
    parameter int DB_CNT   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  col_in,
    output logic [3:0]  row_out,
    output logic [11:0] key_pulse,
    output logic [3:0]  key_code,
    output logic        key_valid,
    output logic        key_held
);
    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [2:0]        col_meta, col_sync;
    row_state_t        state, state_nxt;
    logic [DIV_W-1:0]  div;
    logic              row_last, scan_end;
    logic [SNAP_W-1:0] snap, snap_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_meta <= '0;
            col_sync <= '0;
            state    <= ROW0;
            div      <= '0;
            snap     <= '0;
        end else begin
            col_meta <= col_in;
            col_sync <= col_meta;
            state    <= state_nxt;
            div      <= row_last ? '0 : div + 1'b1;
            snap     <= snap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        row_out   = 4'b1111;
        row_last  = (div == DIV_LAST);
        case (state)
            ROW0: begin row_out = 4'b1110; if (row_last) state_nxt = ROW1; end
            ROW1: begin row_out = 4'b1101; if (row_last) state_nxt = ROW2; end
            ROW2: begin row_out = 4'b1011; if (row_last) state_nxt = ROW3; end
            default: begin row_out = 4'b0111; if (row_last) state_nxt = ROW0; end
        endcase
        // Sampling on the last cycle of the window leaves the two-flop
        // synchroniser time to settle after the row drive changed.
        snap_nxt = snap;
        if (row_last)
            for (int c = 0; c < NUM_COLS; c++)
                snap_nxt[key_index(2'(state), 2'(c))] = ~col_sync[c];
        scan_end = row_last && (state == ROW3);
    end

    // snap_nxt already carries the row-3 bits on the scan-end cycle.
    keypad_debounce #(.DB_CNT(DB_CNT)) u_debounce (
        .clk       (clk),
        .rst       (rst),
        .scan_end  (scan_end),
        .snap      (snap_nxt),
        .key_pulse (key_pulse),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: emulates an ideal 4x3 keypad on the row/column lines and
// checks press pulses, codes, held flag and latency against an event-level
// model of debounced key state.
module tb_keypad_scan;
    localparam int SD      = 4;
    localparam int DB      = 3;
    localparam int HOLD    = 120;
    localparam int LAT_MIN = (DB - 1) * 4 * SD + 1;
    localparam int LAT_MAX = (DB + 1) * 4 * SD + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  col_in;
    logic [3:0]  row_out;
    logic [11:0] key_pulse;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;

    keypad_scan #(.SCAN_DIV(SD), .DB_CNT(DB)) dut (
        .clk(clk), .rst(rst), .col_in(col_in), .row_out(row_out),
        .key_pulse(key_pulse), .key_code(key_code),
        .key_valid(key_valid), .key_held(key_held)
    );

    always #5 clk = ~clk;

    // Physical keypad: a pressed key shorts its column to the driven row.
    int keymap [4][3] = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}, '{10, 0, 11}};
    logic [11:0] pressed = '0;
    always_comb begin
        col_in = 3'b111;
        for (int r = 0; r < 4; r++)
            if (!row_out[r])
                for (int c = 0; c < 3; c++)
                    if (pressed[keymap[r][c]]) col_in[c] = 1'b0;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [11:0] p;
        logic        v;
        logic [3:0]  c;
        int          t;
    } ev_t;
    ev_t evq[$];

    always @(negedge clk)
        if (key_pulse != '0 || key_valid) evq.push_back('{key_pulse, key_valid, key_code, cyc});

    int checks = 0;
    int errors = 0;
    logic [11:0] deb_m  = '0;
    logic [3:0]  code_m = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic check_events(input string tag, input logic [11:0] exp, input int t0);
        int lat;
        chk({tag, "_nev"}, evq.size(), (exp != '0) ? 1 : 0);
        if (exp != '0 && evq.size() == 1) begin
            if ($countones(exp) == 1)
                for (int i = 0; i < 12; i++) if (exp[i]) code_m = 4'(i);
            lat = evq[0].t - t0;
            chk({tag, "_pulse"}, evq[0].p, exp);
            chk({tag, "_valid"}, evq[0].v, ($countones(exp) == 1) ? 1 : 0);
            chk({tag, "_code"},  evq[0].c, code_m);
            chk({tag, "_lat"},   (lat >= LAT_MIN && lat <= LAT_MAX) ? 1 : 0, 1);
        end
    endtask

    // Hold a new key set long enough to settle, then compare.
    task automatic phase(input logic [11:0] nxt, input string tag);
        logic [11:0] exp;
        int t0;
        exp = nxt & ~deb_m;
        evq.delete();
        pressed = nxt;
        t0 = cyc;
        tick(HOLD);
        check_events(tag, exp, t0);
        deb_m = nxt;
        chk({tag, "_held"}, key_held, (nxt != '0) ? 1 : 0);
    endtask

    initial begin
        logic [3:0]  er;
        logic [11:0] nxt;
        int t0;

        // Reset state and row stepping.
        rst = 1'b0;
        tick(2);
        chk("rst_row", row_out, 4'b1110);
        chk("rst_pulse", key_pulse, 0);
        chk("rst_valid", key_valid, 0);
        chk("rst_held", key_held, 0);
        chk("rst_code", key_code, 0);
        rst = 1'b1;
        for (int k = 0; k < 16; k++) begin
            tick(1);
            er = 4'b1111;
            er[((k + 1) / SD) % 4] = 1'b0;
            chk("row_step", row_out, er);
        end

        // Single key press and release.
        phase(12'h002, "k1");
        phase(12'h000, "k1_rel");

        // Bounce: a 32-cycle toggle period reads opposite levels on
        // consecutive scans, so no snapshot pair ever agrees.
        evq.delete();
        for (int i = 0; i < 10; i++) begin
            pressed = pressed ^ 12'h001;
            tick(4 * SD);
        end
        chk("bounce_quiet", evq.size(), 0);
        phase(12'h001, "k0_stable");
        phase(12'h000, "k0_rel");

        // Two simultaneous presses.
        phase(12'h00C, "k23");
        phase(12'h000, "k23_rel");

        // New key while another is held.
        phase(12'h020, "k5");
        phase(12'h220, "k9");
        phase(12'h000, "k59_rel");

        // Random key sets.
        for (int i = 0; i < 14; i++) begin
            case ($urandom_range(0, 3))
                0:       nxt = '0;
                1:       nxt = 12'h001 << $urandom_range(0, 11);
                2:       nxt = deb_m | (12'h001 << $urandom_range(0, 11));
                default: nxt = 12'($urandom());
            endcase
            phase(nxt, "rnd");
        end
        phase(12'h000, "rnd_rel");

        // Reset while '#' is held: state is discarded and '#' re-pulses.
        evq.delete();
        pressed = 12'h800;
        for (int i = 0; i < 100 && evq.size() == 0; i++) tick(1);
        chk("hash_pre_nev", evq.size(), 1);
        rst = 1'b0;
        tick(1);
        chk("hrst_row", row_out, 4'b1110);
        chk("hrst_pulse", key_pulse, 0);
        chk("hrst_valid", key_valid, 0);
        chk("hrst_held", key_held, 0);
        chk("hrst_code", key_code, 0);
        rst = 1'b1;
        deb_m  = '0;
        code_m = '0;
        evq.delete();
        t0 = cyc;
        tick(HOLD);
        check_events("hash_post", 12'h800, t0);
        chk("hash_post_held", key_held, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
